// File: rtl/rlgl_pkg.sv
// rlgl_pkg: types and default constants shared by the player mover, the
// key-repeat helper and the VGA renderer.
//   game_state_t : round state, encoding matches the game_state port
//   dir_t        : resolved direction after priority encoding
//   X_MAX_DEF / Y_MAX_DEF : default grid extent (columns 0..15, rows 0..11)
package rlgl_pkg;

  localparam int unsigned X_MAX_DEF = 15;
  localparam int unsigned Y_MAX_DEF = 11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PLAY   = 2'd1,
    CAUGHT = 2'd2,
    WON    = 2'd3
  } game_state_t;

  typedef enum logic [2:0] {
    NONE  = 3'd0,
    UP    = 3'd1,
    DOWN  = 3'd2,
    LEFT  = 3'd3,
    RIGHT = 3'd4
  } dir_t;

endpackage

// File: rtl/key_repeat.sv
// key_repeat: turns held direction levels into rate-limited step requests.
//   CLK, RST          : clock, synchronous active-high reset
//   up/down/left/right: sticky direction levels
//   dir               : priority-resolved direction (up > down > left > right)
//   req               : one-cycle step request; fires when a direction first
//                       appears, then every STEP_CYCLES cycles while held
module key_repeat
  import rlgl_pkg::*;
#(
  parameter int unsigned STEP_CYCLES = 12500000
) (
  input  logic CLK,
  input  logic RST,
  input  logic up,
  input  logic down,
  input  logic left,
  input  logic right,
  output dir_t dir,
  output logic req
);

  localparam int unsigned CW = (STEP_CYCLES < 2) ? 1 : $clog2(STEP_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STEP_CYCLES - 1);

  dir_t          dir_prev_q;
  logic [CW-1:0] rep_cnt_q, rep_cnt_d;
  logic          dir_changed;

  always_comb begin
    dir = NONE;
    if (up)         dir = UP;
    else if (down)  dir = DOWN;
    else if (left)  dir = LEFT;
    else if (right) dir = RIGHT;
  end

  assign dir_changed = (dir != dir_prev_q);
  assign req         = (dir != NONE) && (dir_changed || (rep_cnt_q == CNT_LAST));

  // Counter restarts on every step so the next one lands STEP_CYCLES later;
  // a new direction restarts it as well so the new key acts immediately.
  always_comb begin
    if ((dir == NONE) || dir_changed || req) rep_cnt_d = '0;
    else                                     rep_cnt_d = rep_cnt_q + CW'(1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      dir_prev_q <= NONE;
      rep_cnt_q  <= '0;
    end else begin
      dir_prev_q <= dir;
      rep_cnt_q  <= rep_cnt_d;
    end
  end

endmodule

// File: rtl/player_mover.sv
// player_mover: grid movement and round state machine for the red-light /
// green-light game.
//   CLK, RST           : clock, synchronous active-high reset
//   up/down/left/right : sticky direction levels from the keyboard decoder
//   space              : start / restart level (acts on rising edge only)
//   red_light          : 1 = red, 0 = green
//   pos_x, pos_y       : registered player cell, row 0 is the goal
//   game_state         : IDLE=0, PLAY=1, CAUGHT=2, WON=3
//   step_pulse         : one-cycle pulse after the position changed
//   caught, won        : state flags
module player_mover
  import rlgl_pkg::*;
#(
  parameter int unsigned X_MAX        = X_MAX_DEF,
  parameter int unsigned Y_MAX        = Y_MAX_DEF,
  parameter int unsigned X_START      = 7,
  parameter int unsigned STEP_CYCLES  = 12500000,
  parameter int unsigned GRACE_CYCLES = 5000000
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       up,
  input  logic                       down,
  input  logic                       left,
  input  logic                       right,
  input  logic                       space,
  input  logic                       red_light,
  output logic [$clog2(X_MAX+1)-1:0] pos_x,
  output logic [$clog2(Y_MAX+1)-1:0] pos_y,
  output logic [1:0]                 game_state,
  output logic                       step_pulse,
  output logic                       caught,
  output logic                       won
);

  localparam int unsigned XW = $clog2(X_MAX + 1);
  localparam int unsigned YW = $clog2(Y_MAX + 1);
  localparam int unsigned GW = (GRACE_CYCLES < 1) ? 1 : $clog2(GRACE_CYCLES + 1);

  localparam logic [XW-1:0] X_HOME  = XW'(X_START);
  localparam logic [XW-1:0] X_LAST  = XW'(X_MAX);
  localparam logic [YW-1:0] Y_HOME  = YW'(Y_MAX);
  localparam logic [YW-1:0] Y_LAST  = YW'(Y_MAX);
  localparam logic [GW-1:0] GRACE_LD = GW'(GRACE_CYCLES);

  game_state_t   state_q, state_d;
  logic [XW-1:0] pos_x_q, pos_x_d;
  logic [YW-1:0] pos_y_q, pos_y_d;
  logic          step_q, step_d;
  logic          space_prev_q, red_prev_q;
  logic [GW-1:0] grace_q, grace_d;

  dir_t dir;
  logic req;
  logic space_rise, red_rise, viol_window;
  logic blocked, do_move, do_catch, reach_goal;

  key_repeat #(.STEP_CYCLES(STEP_CYCLES)) u_key_repeat (
    .CLK   (CLK),
    .RST   (RST),
    .up    (up),
    .down  (down),
    .left  (left),
    .right (right),
    .dir   (dir),
    .req   (req)
  );

  assign space_rise = space & ~space_prev_q;
  assign red_rise   = red_light & ~red_prev_q;

  // Grace reloads on every red rise and otherwise drains while red is on.
  always_comb begin
    grace_d = '0;
    if (red_rise)                        grace_d = GRACE_LD;
    else if (red_light && grace_q != '0) grace_d = grace_q - GW'(1);
  end

  // grace_q is still zero on the rise cycle itself (the load lands next
  // cycle), so the rise is excluded explicitly: a move that coincides with
  // the light turning red is never a violation.
  assign viol_window = red_light && !red_rise && (grace_q == '0);

  always_comb begin
    blocked = 1'b0;
    unique case (dir)
      UP:      blocked = (pos_y_q == '0);
      DOWN:    blocked = (pos_y_q == Y_LAST);
      LEFT:    blocked = (pos_x_q == '0);
      RIGHT:   blocked = (pos_x_q == X_LAST);
      default: blocked = 1'b0;
    endcase
  end

  // Blocked requests are dropped before the violation check, so pushing
  // against a wall under red is harmless.
  assign do_catch   = (state_q == PLAY) && req && !blocked && viol_window;
  assign do_move    = (state_q == PLAY) && req && !blocked && !viol_window;
  assign reach_goal = do_move && (dir == UP) && (pos_y_q == YW'(1));

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      pos_x_q      <= X_HOME;
      pos_y_q      <= Y_HOME;
      step_q       <= 1'b0;
      space_prev_q <= 1'b0;
      red_prev_q   <= 1'b0;
      grace_q      <= '0;
    end else begin
      state_q      <= state_d;
      pos_x_q      <= pos_x_d;
      pos_y_q      <= pos_y_d;
      step_q       <= step_d;
      space_prev_q <= space;
      red_prev_q   <= red_light;
      grace_q      <= grace_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (space_rise) state_d = PLAY;
      PLAY: begin
        if (do_catch)        state_d = CAUGHT;
        else if (reach_goal) state_d = WON;
      end
      CAUGHT,
      WON:     if (space_rise) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Position / pulse logic
  always_comb begin
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    step_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        pos_x_d = X_HOME;
        pos_y_d = Y_HOME;
      end
      PLAY: begin
        if (do_move) begin
          step_d = 1'b1;
          unique case (dir)
            UP:      pos_y_d = pos_y_q - YW'(1);
            DOWN:    pos_y_d = pos_y_q + YW'(1);
            LEFT:    pos_x_d = pos_x_q - XW'(1);
            RIGHT:   pos_x_d = pos_x_q + XW'(1);
            default: ;
          endcase
        end
      end
      default: begin
        if (space_rise) begin
          pos_x_d = X_HOME;
          pos_y_d = Y_HOME;
        end
      end
    endcase
  end

  assign pos_x      = pos_x_q;
  assign pos_y      = pos_y_q;
  assign game_state = state_q;
  assign step_pulse = step_q;
  assign caught     = (state_q == CAUGHT);
  assign won        = (state_q == WON);

endmodule

// File: tb/tb_player_mover.sv
module tb_player_mover;

  localparam int STEP  = 4;
  localparam int GRACE = 3;
  localparam int XM    = 3;
  localparam int YM    = 3;
  localparam int XS    = 1;

  localparam logic [3:0] D_U = 4'b1000;
  localparam logic [3:0] D_D = 4'b0100;
  localparam logic [3:0] D_L = 4'b0010;
  localparam logic [3:0] D_R = 4'b0001;

  logic       CLK = 1'b0;
  logic       RST, up, down, left, right, space, red_light;
  logic [1:0] pos_x, pos_y, game_state;
  logic       step_pulse, caught, won;

  player_mover #(
    .X_MAX(XM), .Y_MAX(YM), .X_START(XS), .STEP_CYCLES(STEP), .GRACE_CYCLES(GRACE)
  ) dut (
    .CLK(CLK), .RST(RST), .up(up), .down(down), .left(left), .right(right),
    .space(space), .red_light(red_light), .pos_x(pos_x), .pos_y(pos_y),
    .game_state(game_state), .step_pulse(step_pulse), .caught(caught), .won(won)
  );

  always #5 CLK = ~CLK;

  int vectors = 0;
  int errors  = 0;

  // Reference model: tracks how long the current key has been held and how
  // long ago the light turned red, and applies the game rules directly.
  int m_state = 0, m_x = XS, m_y = YM, m_dir = 0, m_held = 0, m_age = 0;
  bit m_pulse = 0, m_sp_prev = 0, m_red_prev = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model();
    int  d;
    bit  req, srise, rrise, vw, blk;
    m_pulse = 0;
    if (RST) begin
      m_state = 0; m_x = XS; m_y = YM;
      m_dir = 0; m_held = 0; m_age = 0; m_sp_prev = 0; m_red_prev = 0;
      return;
    end
    d = up ? 1 : down ? 2 : left ? 3 : right ? 4 : 0;
    if (d != m_dir) m_held = 0; else m_held++;
    m_dir = d;
    req   = (d != 0) && (m_held % STEP == 0);
    srise = space && !m_sp_prev;
    rrise = red_light && !m_red_prev;
    if (rrise) m_age = 0; else if (red_light) m_age++;
    vw = red_light && !rrise && (m_age > GRACE);
    m_sp_prev  = space;
    m_red_prev = red_light;
    case (m_state)
      0: if (srise) m_state = 1;
      1: if (req) begin
        blk = (d == 1 && m_y == 0) || (d == 2 && m_y == YM) ||
              (d == 3 && m_x == 0) || (d == 4 && m_x == XM);
        if (!blk) begin
          if (vw) m_state = 2;
          else begin
            m_pulse = 1;
            if (d == 1) m_y--; else if (d == 2) m_y++;
            else if (d == 3) m_x--; else m_x++;
            if (m_y == 0) m_state = 3;
          end
        end
      end
      default: if (srise) begin m_state = 0; m_x = XS; m_y = YM; end
    endcase
  endtask

  task automatic cyc(input logic [3:0] d, input logic sp, input logic rd, input logic rs);
    logic [8:0] exp;
    {up, down, left, right} = d;
    space = sp; red_light = rd; RST = rs;
    model();
    exp = {2'(m_state), 2'(m_x), 2'(m_y), m_pulse, m_state == 2, m_state == 3};
    @(posedge CLK); #1;
    check("outputs", 32'({game_state, pos_x, pos_y, step_pulse, caught, won}), 32'(exp));
  endtask

  initial begin
    int pulses;
    logic [3:0] rd_dir;
    logic rsp, rred;
    {up, down, left, right, space, red_light} = '0;
    RST = 1'b1;

    // reset and start
    cyc(4'b0, 0, 0, 1); cyc(4'b0, 0, 0, 1);
    check("reset_state", 32'(game_state), 32'd0);
    check("reset_pos",   32'({pos_x, pos_y}), 32'({2'd1, 2'd3}));
    check("reset_flags", 32'({step_pulse, caught, won}), 32'd0);
    cyc(4'b0, 1, 0, 0);
    check("start_play", 32'(game_state), 32'd1);
    repeat (3) cyc(4'b0, 1, 0, 0);
    check("space_held", 32'(game_state), 32'd1);
    cyc(4'b0, 0, 0, 0);

    // up held to the goal
    for (int i = 0; i < 9; i++) cyc(D_U, 0, 0, 0);
    check("win_state", 32'({game_state, won, pos_y}), 32'({2'd3, 1'b1, 2'd0}));
    repeat (3) cyc(D_U, 0, 0, 0);
    check("win_frozen", 32'({game_state, pos_x, pos_y}), 32'({2'd3, 2'd1, 2'd0}));

    // restart, then push left into the wall
    cyc(4'b0, 1, 0, 0); cyc(4'b0, 0, 0, 0);
    check("restart_home", 32'({game_state, pos_x, pos_y}), 32'({2'd0, 2'd1, 2'd3}));
    cyc(4'b0, 1, 0, 0); cyc(4'b0, 0, 0, 0);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(D_L, 0, 0, 0);
      pulses += int'(step_pulse);
    end
    check("left_pulses", 32'(pulses), 32'd1);
    check("left_wall",   32'({game_state, pos_x}), 32'({2'd1, 2'd0}));
    cyc(4'b0, 0, 0, 0);

    // grace window then a violation
    cyc(4'b0, 0, 1, 0); cyc(4'b0, 0, 1, 0);
    cyc(D_R, 0, 1, 0);
    check("grace_move", 32'({game_state, pos_x}), 32'({2'd1, 2'd1}));
    cyc(4'b0, 0, 1, 0);
    cyc(D_R, 0, 1, 0);
    check("caught", 32'({caught, game_state, pos_x, step_pulse}), 32'({1'b1, 2'd2, 2'd1, 1'b0}));

    // priority and direction change
    cyc(4'b0, 1, 0, 0); cyc(4'b0, 0, 0, 0); cyc(4'b0, 1, 0, 0); cyc(4'b0, 0, 0, 0);
    cyc(D_U | D_R, 0, 0, 0);
    check("priority_up", 32'({pos_x, pos_y}), 32'({2'd1, 2'd2}));
    cyc(D_R, 0, 0, 0);
    check("dir_change", 32'({pos_x, pos_y, step_pulse}), 32'({2'd2, 2'd2, 1'b1}));

    // reset while the next repeat step is due
    repeat (3) cyc(D_R, 0, 0, 0);
    cyc(D_R, 0, 0, 1);
    check("reset_mid_play", 32'({game_state, pos_x, pos_y, step_pulse}),
          32'({2'd0, 2'd1, 2'd3, 1'b0}));

    // randomized run against the model
    rd_dir = 4'b0; rsp = 0; rred = 0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 5) == 0) rd_dir = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 4) == 0) rsp  = ~rsp;
      if ($urandom_range(0, 9) == 0) rred = ~rred;
      cyc(rd_dir, rsp, rred, ($urandom_range(0, 99) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
